// File: rtl/spi_reg_bridge_if.sv
// Register-bus bridge pin bundle: host SPI pins plus the shared register bus.
// slave = the bridge itself, master = whatever drives SPI and serves read data.
interface spi_reg_bridge_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  i_sclk;
    logic                  i_cs_n;
    logic                  i_mosi;
    logic                  o_miso;
    logic                  o_miso_oe;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_wr;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_busy;
    logic                  o_frame_err;

    modport slave (
        input  i_sclk, i_cs_n, i_mosi, i_data,
        output o_miso, o_miso_oe, o_addr, o_data, o_wr, o_busy, o_frame_err
    );

    modport master (
        output i_sclk, i_cs_n, i_mosi, i_data,
        input  o_miso, o_miso_oe, o_addr, o_data, o_wr, o_busy, o_frame_err
    );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI (mode 0, MSB first) to register-bus initiator: one read or write per CS frame.
// Read data captured RD_LAT clks after o_addr; no backpressure, host paces frames via SCLK/CS.
module spi_reg_bridge #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LAT     = 2
) (
    input  logic              i_clk_10,
    input  logic              i_rst,
    spi_reg_bridge_if.slave   bus
);
    localparam int MAXW  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W = $clog2(MAXW + 1);
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [LAT_W-1:0] LAT_ONE   = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_RD_WAIT, S_RDATA, S_WDATA, S_WSTROBE, S_DONE
    } state_t;

    logic sclk_meta_q, sclk_meta_d, sclk_sync_q, sclk_sync_d, sclk_prev_q, sclk_prev_d;
    logic cs_meta_q, cs_meta_d, cs_sync_q, cs_sync_d, cs_prev_q, cs_prev_d;
    logic mosi_meta_q, mosi_meta_d, mosi_sync_q, mosi_sync_d;
    logic sclk_rise, sclk_fall, cs_fall;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic                  rw_q, rw_d;
    logic [MAXW-1:0]       shift_q, shift_d, shift_in;
    logic [DATA_WIDTH-2:0] tx_q, tx_d;
    logic                  extra_q, extra_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  wr_q, wr_d;
    logic                  miso_q, miso_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    always_comb begin
        sclk_meta_d = bus.i_sclk;
        sclk_sync_d = sclk_meta_q;
        sclk_prev_d = sclk_sync_q;
        cs_meta_d   = bus.i_cs_n;
        cs_sync_d   = cs_meta_q;
        cs_prev_d   = cs_sync_q;
        mosi_meta_d = bus.i_mosi;
        mosi_sync_d = mosi_meta_q;
    end

    // Synchronizers are deliberately not reset: a reset while CS is held low must
    // not look like a fresh CS fall, so the remainder of that frame is ignored.
    always_ff @(posedge i_clk_10) begin
        sclk_meta_q <= sclk_meta_d;
        sclk_sync_q <= sclk_sync_d;
        sclk_prev_q <= sclk_prev_d;
        cs_meta_q   <= cs_meta_d;
        cs_sync_q   <= cs_sync_d;
        cs_prev_q   <= cs_prev_d;
        mosi_meta_q <= mosi_meta_d;
        mosi_sync_q <= mosi_sync_d;
    end

    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
    assign cs_fall   = cs_prev_q & ~cs_sync_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lat_d    = lat_q;
        rw_d     = rw_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        extra_d  = extra_q;
        addr_d   = addr_q;
        data_d   = data_q;
        miso_d   = miso_q;
        wr_d     = 1'b0;
        err_d    = 1'b0;
        shift_in = {shift_q[MAXW-2:0], mosi_sync_q};

        unique case (state_q)
            S_IDLE: begin
                if (cs_fall) begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                    extra_d = 1'b0;
                end
            end
            S_CMD: begin
                if (sclk_rise) begin
                    rw_d    = mosi_sync_q;
                    cnt_d   = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (sclk_rise) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + CNT_ONE;
                    if (cnt_q == ADDR_LAST) begin
                        addr_d  = shift_in[ADDR_WIDTH-1:0];
                        cnt_d   = '0;
                        lat_d   = '0;
                        state_d = rw_q ? S_WDATA : S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT: begin
                // SCLK falls seen here belong to the last address bit and must not shift.
                lat_d = lat_q + LAT_ONE;
                if (lat_q == LAT_LAST) begin
                    tx_d    = bus.i_data[DATA_WIDTH-2:0];
                    miso_d  = bus.i_data[DATA_WIDTH-1];
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                if (sclk_rise) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == DATA_LAST) begin
                        state_d = S_DONE;
                    end
                end else if (sclk_fall && (cnt_q != '0)) begin
                    miso_d = tx_q[DATA_WIDTH-2];
                    tx_d   = tx_q << 1;
                end
            end
            S_WDATA: begin
                if (sclk_rise) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + CNT_ONE;
                    if (cnt_q == DATA_LAST) begin
                        state_d = S_WSTROBE;
                    end
                end
            end
            S_WSTROBE: begin
                data_d  = shift_q[DATA_WIDTH-1:0];
                wr_d    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (cs_sync_q) begin
                    state_d = S_IDLE;
                    err_d   = extra_q;
                end else if (sclk_rise) begin
                    extra_d = 1'b1;
                end
            end
        endcase

        if (cs_sync_q && (state_q inside {S_CMD, S_ADDR, S_RD_WAIT, S_RDATA, S_WDATA})) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end

        if (state_d == S_IDLE) begin
            miso_d = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk_10) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
            rw_q    <= 1'b0;
            shift_q <= '0;
            tx_q    <= '0;
            extra_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            miso_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            rw_q    <= rw_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            extra_q <= extra_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            miso_q  <= miso_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_addr      = addr_q;
    assign bus.o_data      = data_q;
    assign bus.o_wr        = wr_q;
    assign bus.o_miso      = miso_q;
    assign bus.o_miso_oe   = busy_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_frame_err = err_q;
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: table vectors, hand-written corner frames, random frames vs a frame-level model.
module tb_spi_reg_bridge;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int FL = 1 + AW + DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #50 clk = ~clk;

    spi_reg_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    spi_reg_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(2)) dut (
        .i_clk_10 (clk),
        .i_rst    (rst),
        .bus      (bus)
    );

    // Register file: one-clock registered read, write on o_wr.
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] rd_q;
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_a  = '0;
    logic [DW-1:0] pre_d  = '0;
    always @(posedge clk) begin
        if (pre_en) mem[pre_a] <= pre_d;
        else if (bus.o_wr) mem[bus.o_addr] <= bus.o_data;
        rd_q <= mem[bus.o_addr];
    end
    assign bus.i_data = rd_q;

    int wr_cnt = 0;
    int err_cnt = 0;
    always @(negedge clk) begin
        if (bus.o_wr === 1'b1) wr_cnt++;
        if (bus.o_frame_err === 1'b1) err_cnt++;
    end

    int n_chk = 0;
    int n_err = 0;
    int gap_clks = 6;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame-level reference: what a whole CS frame of nbits clocks should do.
    logic [DW-1:0] ref_mem [0:255];
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;

    task automatic model_frame(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input int nbits, input int rst_at,
                               output int e_wr, output int e_err, output bit e_chk,
                               output logic [DW-1:0] e_rd);
        e_wr = 0; e_err = 0; e_chk = 1'b0; e_rd = '0;
        if (rst_at >= 0) begin
            m_addr = '0;
            m_data = '0;
            return;
        end
        if (nbits >= 1 + AW) m_addr = a;
        if (nbits != FL) e_err = 1;
        if (nbits >= FL) begin
            if (rw) begin
                ref_mem[a] = d;
                m_data = d;
                e_wr = 1;
            end else begin
                e_chk = 1'b1;
                e_rd = ref_mem[a];
            end
        end
    endtask

    task automatic spi_frame(input string tag, input bit rw, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input int nbits, input int rst_at,
                             output logic [DW-1:0] rdata);
        logic [FL-1:0] fb;
        fb = {rw, a, d};
        rdata = '0;
        @(negedge clk) bus.i_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check({tag, "_rst_addr"}, 32'(bus.o_addr), 32'h0);
                check({tag, "_rst_data"}, 32'(bus.o_data), 32'h0);
                check({tag, "_rst_busy"}, 32'(bus.o_busy), 32'h0);
                check({tag, "_rst_oe"},   32'(bus.o_miso_oe), 32'h0);
                check({tag, "_rst_miso"}, 32'(bus.o_miso), 32'h0);
                check({tag, "_rst_wr"},   32'(bus.o_wr), 32'h0);
                rst = 1'b0;
            end
            if (i == 1 && rst_at < 0) begin
                check({tag, "_busy_mid"}, 32'(bus.o_busy), 32'h1);
                check({tag, "_oe_mid"},   32'(bus.o_miso_oe), 32'h1);
            end
            bus.i_mosi = (i < FL) ? fb[FL-1-i] : 1'b0;
            repeat (4) @(negedge clk);
            if (i >= 1 + AW && i < FL) rdata = {rdata[DW-2:0], bus.o_miso};
            bus.i_sclk = 1'b1;
            repeat (4) @(negedge clk);
            bus.i_sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        bus.i_cs_n = 1'b1;
        repeat (gap_clks) @(negedge clk);
    endtask

    task automatic do_frame(input string tag, input bit rw, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input int nbits, input int rst_at,
                            input int x_wr, input int x_err, input logic [AW-1:0] x_addr,
                            input logic [DW-1:0] x_data, input bit x_chk, input logic [DW-1:0] x_rd);
        int w0, e0;
        logic [DW-1:0] rdata;
        w0 = wr_cnt;
        e0 = err_cnt;
        spi_frame(tag, rw, a, d, nbits, rst_at, rdata);
        check({tag, "_wr_pulses"},  32'(wr_cnt - w0), 32'(x_wr));
        check({tag, "_err_pulses"}, 32'(err_cnt - e0), 32'(x_err));
        check({tag, "_addr"}, 32'(bus.o_addr), 32'(x_addr));
        check({tag, "_data"}, 32'(bus.o_data), 32'(x_data));
        check({tag, "_busy_end"}, 32'(bus.o_busy), 32'h0);
        check({tag, "_oe_end"},   32'(bus.o_miso_oe), 32'h0);
        check({tag, "_miso_end"}, 32'(bus.o_miso), 32'h0);
        if (x_chk) check({tag, "_rdata"}, 32'(rdata), 32'(x_rd));
    endtask

    typedef struct {
        bit            rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            nbits;
        int            exp_wr;
        int            exp_err;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        bit            chk_rd;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e_wr, e_err;
        bit e_chk;
        logic [DW-1:0] e_rd;
        bit rw;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int nb;

        vecs[0] = '{rw:1'b1, addr:8'h07, data:8'hA5, nbits:FL,   exp_wr:1, exp_err:0, exp_addr:8'h07, exp_data:8'hA5, chk_rd:1'b0, exp_rd:8'h00};
        vecs[1] = '{rw:1'b0, addr:8'h02, data:8'h00, nbits:FL,   exp_wr:0, exp_err:0, exp_addr:8'h02, exp_data:8'hA5, chk_rd:1'b1, exp_rd:8'h3C};
        vecs[2] = '{rw:1'b1, addr:8'h10, data:8'hFF, nbits:13,   exp_wr:0, exp_err:1, exp_addr:8'h10, exp_data:8'hA5, chk_rd:1'b0, exp_rd:8'h00};
        vecs[3] = '{rw:1'b1, addr:8'h20, data:8'h5A, nbits:FL+3, exp_wr:1, exp_err:1, exp_addr:8'h20, exp_data:8'h5A, chk_rd:1'b0, exp_rd:8'h00};
        vecs[4] = '{rw:1'b0, addr:8'h07, data:8'hFF, nbits:FL,   exp_wr:0, exp_err:0, exp_addr:8'h07, exp_data:8'h5A, chk_rd:1'b1, exp_rd:8'hA5};
        vecs[5] = '{rw:1'b1, addr:8'h0F, data:8'hC3, nbits:FL,   exp_wr:1, exp_err:0, exp_addr:8'h0F, exp_data:8'hC3, chk_rd:1'b0, exp_rd:8'h00};
        vecs[6] = '{rw:1'b0, addr:8'h02, data:8'h00, nbits:5,    exp_wr:0, exp_err:1, exp_addr:8'h0F, exp_data:8'hC3, chk_rd:1'b0, exp_rd:8'h00};
        vecs[7] = '{rw:1'b1, addr:8'h33, data:8'h00, nbits:1,    exp_wr:0, exp_err:1, exp_addr:8'h0F, exp_data:8'hC3, chk_rd:1'b0, exp_rd:8'h00};

        bus.i_sclk = 1'b0;
        bus.i_cs_n = 1'b1;
        bus.i_mosi = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_addr", 32'(bus.o_addr), 32'h0);
        check("reset_data", 32'(bus.o_data), 32'h0);
        check("reset_wr",   32'(bus.o_wr), 32'h0);
        check("reset_miso", 32'(bus.o_miso), 32'h0);
        check("reset_oe",   32'(bus.o_miso_oe), 32'h0);
        check("reset_busy", 32'(bus.o_busy), 32'h0);
        check("reset_err",  32'(bus.o_frame_err), 32'h0);

        for (int i = 0; i < 16; i++) begin
            pre_en = 1'b1;
            pre_a  = AW'(i);
            pre_d  = (i == 2) ? 8'h3C : DW'($urandom);
            ref_mem[i] = pre_d;
            @(negedge clk);
        end
        pre_en = 1'b0;

        for (int k = 0; k < 8; k++) begin
            model_frame(vecs[k].rw, vecs[k].addr, vecs[k].data, vecs[k].nbits, -1, e_wr, e_err, e_chk, e_rd);
            do_frame($sformatf("vec%0d", k), vecs[k].rw, vecs[k].addr, vecs[k].data, vecs[k].nbits, -1,
                     vecs[k].exp_wr, vecs[k].exp_err, vecs[k].exp_addr, vecs[k].exp_data,
                     vecs[k].chk_rd, vecs[k].exp_rd);
        end

        // Reset in the middle of the address field, then a clean frame.
        model_frame(1'b1, 8'h0A, 8'h77, FL, 5, e_wr, e_err, e_chk, e_rd);
        do_frame("rst_mid", 1'b1, 8'h0A, 8'h77, FL, 5, 0, 0, 8'h00, 8'h00, 1'b0, 8'h00);
        model_frame(1'b1, 8'h0B, 8'h99, FL, -1, e_wr, e_err, e_chk, e_rd);
        do_frame("after_rst", 1'b1, 8'h0B, 8'h99, FL, -1, 1, 0, 8'h0B, 8'h99, 1'b0, 8'h00);

        // Back-to-back write then read with the minimum CS-high gap.
        gap_clks = 3;
        model_frame(1'b1, 8'h01, 8'h11, FL, -1, e_wr, e_err, e_chk, e_rd);
        do_frame("b2b_wr", 1'b1, 8'h01, 8'h11, FL, -1, 1, 0, 8'h01, 8'h11, 1'b0, 8'h00);
        model_frame(1'b0, 8'h01, 8'h00, FL, -1, e_wr, e_err, e_chk, e_rd);
        do_frame("b2b_rd", 1'b0, 8'h01, 8'h00, FL, -1, 0, 0, 8'h01, 8'h11, 1'b1, 8'h11);
        gap_clks = 6;

        for (int k = 0; k < 30; k++) begin
            rw = 1'($urandom_range(0, 1));
            a  = AW'($urandom_range(0, 15));
            d  = DW'($urandom);
            nb = ($urandom_range(0, 9) < 6) ? FL : int'($urandom_range(0, FL + 4));
            model_frame(rw, a, d, nb, -1, e_wr, e_err, e_chk, e_rd);
            do_frame($sformatf("rnd%0d", k), rw, a, d, nb, -1, e_wr, e_err, m_addr, m_data, e_chk, e_rd);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
